ext_pc_responder: RTL and testbench

- Framework-side responder for the extension interface: the point-cloud end that extensions such as range filters, voxelizers and classifiers talk to.
- Holds one frame of Cartesian points in on-chip RAM and asserts EXT_enable and EXT_PCSize.
- Serves EXT_readReady/EXT_readID requests with point data, and captures EXT_writeCustomField per EXT_writeID into a label RAM.
- Closes the frame on EXT_doneProcessing; labels are then read back by the host-side DMA.

---
 rtl/ext_if_pkg.sv | 33 +++
 rtl/ext_pc_ram.sv | 28 ++
 rtl/ext_pc_responder.sv | 194 +++++++++++++++++++
 tb/tb_ext_pc_responder.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_if_pkg.sv
// Shared definitions for the point-cloud extension interface: widths,
// responder state encoding and the status word layout extensions decode.
package ext_if_pkg;

  localparam int MAX_POINTS_DEF = 1024;
  localparam int ID_W_DEF       = 19;
  localparam int COORD_W_DEF    = 16;
  localparam int CF_W_DEF       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLOSE = 2'd2
  } ext_state_e;

  localparam int STAT_W         = 32;
  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_RD_ERR    = 2;
  localparam int STAT_WR_ERR    = 3;
  localparam int STAT_START_REJ = 4;

  function automatic logic [STAT_W-1:0] pack_status(ext_state_e st, logic rd_err,
                                                   logic wr_err, logic start_rej);
    logic [STAT_W-1:0] s;
    s = '0;
    s[STAT_STATE_LSB +: 2] = st;
    s[STAT_RD_ERR]         = rd_err;
    s[STAT_WR_ERR]         = wr_err;
    s[STAT_START_REJ]      = start_rej;
    return s;
  endfunction

endpackage

// File: rtl/ext_pc_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with a
// registered, enable-gated read (read data holds while re_i is low).
module ext_pc_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read-before-write: a same-address read in the write cycle sees old data.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ext_pc_responder.sv
// Framework-side point-cloud responder: holds one frame of points, serves
// extension reads, captures per-point labels and closes the frame on done.
module ext_pc_responder
  import ext_if_pkg::*;
#(
  parameter int MAX_POINTS = MAX_POINTS_DEF,
  parameter int ID_W       = ID_W_DEF,
  parameter int COORD_W    = COORD_W_DEF,
  parameter int CF_W       = CF_W_DEF
) (
  input  logic               i_SYSTEM_clk,
  input  logic               i_SYSTEM_rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [ID_W-1:0]    load_id,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  logic [COORD_W-1:0] load_z,
  input  logic               start,
  input  logic [ID_W-1:0]    start_pc_size,
  output logic               EXT_enable,
  output logic [ID_W-1:0]    EXT_PCSize,
  input  logic               EXT_readReady,
  input  logic [ID_W-1:0]    EXT_readID,
  output logic               EXT_readValid,
  output logic [COORD_W-1:0] EXT_pointX,
  output logic [COORD_W-1:0] EXT_pointY,
  output logic [COORD_W-1:0] EXT_pointZ,
  output logic [CF_W-1:0]    EXT_readCustomField,
  input  logic               EXT_writeValid,
  output logic               EXT_writeReady,
  input  logic [ID_W-1:0]    EXT_writeID,
  input  logic [CF_W-1:0]    EXT_writeCustomField,
  input  logic               EXT_doneProcessing,
  input  logic [ID_W-1:0]    lbl_addr,
  output logic [CF_W-1:0]    lbl_data,
  output logic               o_frame_done,
  output logic [31:0]        o_write_count,
  output logic [31:0]        o_status
);

  localparam int AW = $clog2(MAX_POINTS);
  localparam int PW = 3 * COORD_W;
  localparam logic [ID_W-1:0] MAX_ID = ID_W'(MAX_POINTS);

  ext_state_e state_q, state_d;

  logic [ID_W-1:0]       pc_size_q;
  logic [MAX_POINTS-1:0] lbl_vld_q;
  logic                  armed_q, rd_pend_q, rd_ok_q, rd_lblv_q;
  logic                  wr_block_q, lbl_out_vld_q;
  logic [31:0]           wr_cnt_q, write_count_q;
  logic                  err_rd_q, err_wr_q, err_st_q;

  logic rd_issue, rd_in_range, wr_accept, wr_in_range, wr_commit;
  logic start_size_ok, start_accept, load_we, lbl_addr_ok;

  logic [PW-1:0]      pt_rdata;
  logic [CF_W-1:0]    lbl_rd_rdata, lbl_host_rdata;
  logic [COORD_W-1:0] coord_out [3];

  assign start_size_ok = (start_pc_size != '0) && (start_pc_size <= MAX_ID);
  assign start_accept  = (state_q == ST_IDLE) && start && start_size_ok;
  assign load_we       = (state_q == ST_IDLE) && load_valid && (load_id < MAX_ID);

  // A held request is answered once; armed_q re-arms only after readReady drops.
  assign rd_issue    = (state_q == ST_RUN) && EXT_readReady && armed_q;
  assign rd_in_range = EXT_readID < pc_size_q;

  assign EXT_writeReady = (state_q == ST_RUN) && !wr_block_q;
  assign wr_accept      = EXT_writeValid && EXT_writeReady;
  assign wr_in_range    = EXT_writeID < pc_size_q;
  assign wr_commit      = wr_accept && wr_in_range;

  assign lbl_addr_ok = lbl_addr < MAX_ID;

  always_ff @(posedge i_SYSTEM_clk) begin
    if (i_SYSTEM_rst) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_accept) state_d = ST_RUN;
      ST_RUN:   if (EXT_doneProcessing) state_d = ST_CLOSE;
      ST_CLOSE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_SYSTEM_clk) begin
    if (i_SYSTEM_rst) begin
      pc_size_q     <= '0;
      lbl_vld_q     <= '0;
      armed_q       <= 1'b1;
      rd_pend_q     <= 1'b0;
      rd_ok_q       <= 1'b0;
      rd_lblv_q     <= 1'b0;
      wr_block_q    <= 1'b0;
      lbl_out_vld_q <= 1'b0;
      wr_cnt_q      <= '0;
      write_count_q <= '0;
      err_rd_q      <= 1'b0;
      err_wr_q      <= 1'b0;
      err_st_q      <= 1'b0;
    end else begin
      if (start_accept) begin
        pc_size_q <= start_pc_size;
        lbl_vld_q <= '0;
        wr_cnt_q  <= '0;
        err_rd_q  <= 1'b0;
        err_wr_q  <= 1'b0;
        err_st_q  <= 1'b0;
      end else if ((state_q == ST_IDLE) && start) begin
        err_st_q <= 1'b1;
      end

      rd_pend_q <= rd_issue;
      if (rd_issue) begin
        armed_q   <= 1'b0;
        rd_ok_q   <= rd_in_range;
        rd_lblv_q <= rd_in_range && lbl_vld_q[EXT_readID[AW-1:0]];
        if (!rd_in_range) err_rd_q <= 1'b1;
      end else if (!EXT_readReady) begin
        armed_q <= 1'b1;
      end

      // Every accept, even a dropped out-of-range one, costs a ready-low cycle.
      wr_block_q <= wr_accept;
      if (wr_accept) begin
        if (wr_in_range) begin
          lbl_vld_q[EXT_writeID[AW-1:0]] <= 1'b1;
          if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 32'd1;
        end else begin
          err_wr_q <= 1'b1;
        end
      end

      if (state_q == ST_CLOSE) write_count_q <= wr_cnt_q;
      lbl_out_vld_q <= lbl_addr_ok && lbl_vld_q[lbl_addr[AW-1:0]];
    end
  end

  ext_pc_ram #(.DATA_W(PW), .DEPTH(MAX_POINTS), .AW(AW)) u_pt_ram (
    .clk_i   (i_SYSTEM_clk),
    .we_i    (load_we),
    .waddr_i (load_id[AW-1:0]),
    .wdata_i ({load_x, load_y, load_z}),
    .re_i    (rd_issue),
    .raddr_i (EXT_readID[AW-1:0]),
    .rdata_o (pt_rdata)
  );

  // Two label copies so the host readout never contends with extension reads.
  ext_pc_ram #(.DATA_W(CF_W), .DEPTH(MAX_POINTS), .AW(AW)) u_lbl_rd_ram (
    .clk_i   (i_SYSTEM_clk),
    .we_i    (wr_commit),
    .waddr_i (EXT_writeID[AW-1:0]),
    .wdata_i (EXT_writeCustomField),
    .re_i    (rd_issue),
    .raddr_i (EXT_readID[AW-1:0]),
    .rdata_o (lbl_rd_rdata)
  );

  ext_pc_ram #(.DATA_W(CF_W), .DEPTH(MAX_POINTS), .AW(AW)) u_lbl_host_ram (
    .clk_i   (i_SYSTEM_clk),
    .we_i    (wr_commit),
    .waddr_i (EXT_writeID[AW-1:0]),
    .wdata_i (EXT_writeCustomField),
    .re_i    (1'b1),
    .raddr_i (lbl_addr[AW-1:0]),
    .rdata_o (lbl_host_rdata)
  );

  for (genvar gi = 0; gi < 3; gi++) begin : g_coord
    assign coord_out[gi] = rd_ok_q ? pt_rdata[gi*COORD_W +: COORD_W] : '0;
  end

  assign EXT_pointX          = coord_out[2];
  assign EXT_pointY          = coord_out[1];
  assign EXT_pointZ          = coord_out[0];
  assign EXT_readCustomField = rd_lblv_q ? lbl_rd_rdata : '0;
  assign EXT_readValid       = rd_pend_q;

  assign load_ready    = (state_q == ST_IDLE);
  assign EXT_enable    = (state_q == ST_RUN);
  assign EXT_PCSize    = pc_size_q;
  assign o_frame_done  = (state_q == ST_CLOSE);
  assign o_write_count = write_count_q;
  assign lbl_data      = lbl_out_vld_q ? lbl_host_rdata : '0;
  assign o_status      = pack_status(state_q, err_rd_q, err_wr_q, err_st_q);

endmodule

// File: tb/tb_ext_pc_responder.sv
// Self-checking bench: cycle-level behavioural model of the responder, compared
// every cycle, plus directed scenarios with literal expectations.
module tb_ext_pc_responder;

  localparam int MAXP = 1024;
  localparam int IDW  = 19;
  localparam int CW   = 16;
  localparam int CFW  = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_valid, load_ready, start;
  logic [IDW-1:0] load_id, start_pc_size, EXT_PCSize, EXT_readID, EXT_writeID, lbl_addr;
  logic [CW-1:0]  load_x, load_y, load_z, EXT_pointX, EXT_pointY, EXT_pointZ;
  logic           EXT_enable, EXT_readReady, EXT_readValid;
  logic           EXT_writeValid, EXT_writeReady, EXT_doneProcessing, o_frame_done;
  logic [CFW-1:0] EXT_readCustomField, EXT_writeCustomField, lbl_data;
  logic [31:0]    o_write_count, o_status;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ext_pc_responder #(.MAX_POINTS(MAXP), .ID_W(IDW), .COORD_W(CW), .CF_W(CFW)) dut (
    .i_SYSTEM_clk        (clk),
    .i_SYSTEM_rst        (rst),
    .load_valid          (load_valid),
    .load_ready          (load_ready),
    .load_id             (load_id),
    .load_x              (load_x),
    .load_y              (load_y),
    .load_z              (load_z),
    .start               (start),
    .start_pc_size       (start_pc_size),
    .EXT_enable          (EXT_enable),
    .EXT_PCSize          (EXT_PCSize),
    .EXT_readReady       (EXT_readReady),
    .EXT_readID          (EXT_readID),
    .EXT_readValid       (EXT_readValid),
    .EXT_pointX          (EXT_pointX),
    .EXT_pointY          (EXT_pointY),
    .EXT_pointZ          (EXT_pointZ),
    .EXT_readCustomField (EXT_readCustomField),
    .EXT_writeValid      (EXT_writeValid),
    .EXT_writeReady      (EXT_writeReady),
    .EXT_writeID         (EXT_writeID),
    .EXT_writeCustomField(EXT_writeCustomField),
    .EXT_doneProcessing  (EXT_doneProcessing),
    .lbl_addr            (lbl_addr),
    .lbl_data            (lbl_data),
    .o_frame_done        (o_frame_done),
    .o_write_count       (o_write_count),
    .o_status            (o_status)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_state;          // 0 idle, 1 run, 2 close
  bit [15:0]   px [MAXP];
  bit [15:0]   py [MAXP];
  bit [15:0]   pz [MAXP];
  bit [15:0]   lb [MAXP];
  bit          lv [MAXP];
  int          m_size;
  bit          e_rd, e_wr, e_st;
  longint      m_cnt;
  longint      m_wcount;
  bit          m_fresh;          // request line seen low since last answered request
  bit          m_resp;
  bit [15:0]   r_x, r_y, r_z, r_cf, m_lbl_out;
  bit          m_blk;

  task automatic model_reset();
    m_state = 0; m_size = 0; e_rd = 0; e_wr = 0; e_st = 0;
    m_cnt = 0; m_wcount = 0; m_fresh = 1; m_resp = 0; m_blk = 0;
    r_x = 0; r_y = 0; r_z = 0; r_cf = 0; m_lbl_out = 0;
    for (int i = 0; i < MAXP; i++) lv[i] = 0;
  endtask

  task automatic model_step();
    int  rid, wid, la, lid, sz;
    bit  req, acc;
    bit [15:0] new_lbl;
    if (rst) begin
      model_reset();
      return;
    end
    rid = int'(EXT_readID); wid = int'(EXT_writeID);
    la  = int'(lbl_addr);   lid = int'(load_id); sz = int'(start_pc_size);
    new_lbl = (la < MAXP && lv[la]) ? lb[la] : 16'h0;
    req = (m_state == 1) && EXT_readReady && m_fresh;
    if (req) begin
      m_fresh = 0;
      if (rid < m_size) begin
        r_x = px[rid]; r_y = py[rid]; r_z = pz[rid];
        r_cf = lv[rid] ? lb[rid] : 16'h0;
      end else begin
        r_x = 0; r_y = 0; r_z = 0; r_cf = 0; e_rd = 1;
      end
    end else if (!EXT_readReady) begin
      m_fresh = 1;
    end
    m_resp = req;
    acc = (m_state == 1) && !m_blk && EXT_writeValid;
    m_blk = acc;
    if (acc) begin
      if (wid < m_size) begin
        lb[wid] = EXT_writeCustomField; lv[wid] = 1;
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      end else e_wr = 1;
    end
    case (m_state)
      0: begin
        if (load_valid && lid < MAXP) begin
          px[lid] = load_x; py[lid] = load_y; pz[lid] = load_z;
        end
        if (start) begin
          if (sz > 0 && sz <= MAXP) begin
            m_size = sz; m_cnt = 0; e_rd = 0; e_wr = 0; e_st = 0; m_state = 1;
            for (int i = 0; i < MAXP; i++) lv[i] = 0;
          end else e_st = 1;
        end
      end
      1: if (EXT_doneProcessing) m_state = 2;
      default: begin m_wcount = m_cnt; m_state = 0; end
    endcase
    m_lbl_out = new_lbl;
  endtask

  task automatic compare();
    chk("load_ready",  32'(load_ready),          32'(m_state == 0));
    chk("enable",      32'(EXT_enable),          32'(m_state == 1));
    chk("pcsize",      32'(EXT_PCSize),          32'(m_size));
    chk("read_valid",  32'(EXT_readValid),       32'(m_resp));
    chk("point_x",     32'(EXT_pointX),          32'(r_x));
    chk("point_y",     32'(EXT_pointY),          32'(r_y));
    chk("point_z",     32'(EXT_pointZ),          32'(r_z));
    chk("read_cf",     32'(EXT_readCustomField), 32'(r_cf));
    chk("write_ready", 32'(EXT_writeReady),      32'(m_state == 1 && !m_blk));
    chk("lbl_data",    32'(lbl_data),            32'(m_lbl_out));
    chk("frame_done",  32'(o_frame_done),        32'(m_state == 2));
    chk("write_count", o_write_count,            m_wcount[31:0]);
    chk("status",      o_status, {27'd0, e_st, e_wr, e_rd, 2'(m_state)});
  endtask

  initial model_reset();

  always @(posedge clk) begin
    model_step();
    #1;
    compare();
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    load_valid = 0; load_id = '0; load_x = '0; load_y = '0; load_z = '0;
    start = 0; start_pc_size = '0; EXT_readReady = 0; EXT_readID = '0;
    EXT_writeValid = 0; EXT_writeID = '0; EXT_writeCustomField = '0;
    EXT_doneProcessing = 0; lbl_addr = '0;
  endtask

  task automatic do_start(input int sz);
    start = 1; start_pc_size = IDW'(sz);
    @(negedge clk);
    start = 0;
  endtask

  initial begin
    int pulses, accepts, sz;
    idle_inputs();
    rst = 1;
    @(negedge clk); @(negedge clk);
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_enable",     32'(EXT_enable), 32'd0);
    chk("rst_status",     o_status,        32'd0);
    rst = 0;

    for (int i = 0; i < 64; i++) begin
      load_valid = 1; load_id = IDW'(i);
      if (i < 4) begin
        load_x = 16'h1000 + 16'(i); load_y = 16'h2000 + 16'(i); load_z = 16'h3000 + 16'(i);
      end else begin
        load_x = 16'($urandom); load_y = 16'($urandom); load_z = 16'($urandom);
      end
      @(negedge clk);
    end
    load_valid = 0;

    do_start(4);
    chk("start_enable", 32'(EXT_enable), 32'd1);
    chk("start_pcsize", 32'(EXT_PCSize), 32'd4);
    chk("start_state",  o_status,        32'd1);

    // held read request: one response only
    EXT_readReady = 1; EXT_readID = 2; pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("rd2_valid", 32'(EXT_readValid), 32'd1);
        chk("rd2_x", 32'(EXT_pointX), 32'h1002);
        chk("rd2_y", 32'(EXT_pointY), 32'h2002);
        chk("rd2_z", 32'(EXT_pointZ), 32'h3002);
        $display("read id=2 x=%h y=%h z=%h", EXT_pointX, EXT_pointY, EXT_pointZ);
      end
      if (i == 1) begin
        chk("rd2_valid_drop", 32'(EXT_readValid), 32'd0);
        chk("rd2_x_held",     32'(EXT_pointX),    32'h1002);
      end
      pulses += int'(EXT_readValid);
    end
    chk("held_req_pulses", 32'(pulses), 32'd1);
    EXT_readReady = 0;
    @(negedge clk);
    EXT_readReady = 1; EXT_readID = 3;
    @(negedge clk);
    chk("rd3_valid", 32'(EXT_readValid), 32'd1);
    chk("rd3_y",     32'(EXT_pointY),    32'h2003);
    $display("read id=3 y=%h", EXT_pointY);
    EXT_readReady = 0;
    @(negedge clk);

    // held write: the forced low ready cycle blocks a repeat
    EXT_writeValid = 1; EXT_writeID = 1; EXT_writeCustomField = 16'h0002; accepts = 0;
    for (int i = 0; i < 2; i++) begin
      accepts += int'(EXT_writeReady);
      @(negedge clk);
      if (i == 0) chk("wr_ready_low", 32'(EXT_writeReady), 32'd0);
    end
    chk("held_wr_accepts", 32'(accepts), 32'd1);
    EXT_writeValid = 0;
    chk("wr_ready_back", 32'(EXT_writeReady), 32'd1);
    $display("write id=1 cf=0002");
    for (int i = 0; i < 4; i++) begin
      if (i == 1) continue;
      EXT_writeValid = 1; EXT_writeID = IDW'(i); EXT_writeCustomField = 16'h0010 + 16'(i);
      @(negedge clk);
      EXT_writeValid = 0;
      @(negedge clk);
      $display("write id=%0d cf=%h", i, 16'h0010 + 16'(i));
    end

    // same-cycle read and write at the same ID returns the old label
    EXT_readReady = 1; EXT_readID = 1;
    EXT_writeValid = 1; EXT_writeID = 1; EXT_writeCustomField = 16'h0055;
    @(negedge clk);
    chk("collide_valid", 32'(EXT_readValid),       32'd1);
    chk("collide_old",   32'(EXT_readCustomField), 32'h0002);
    EXT_readReady = 0; EXT_writeValid = 0;
    @(negedge clk);
    EXT_readReady = 1;
    @(negedge clk);
    chk("rd1_new_cf", 32'(EXT_readCustomField), 32'h0055);
    EXT_readReady = 0;
    @(negedge clk);

    // out-of-range read
    EXT_readReady = 1; EXT_readID = 7;
    @(negedge clk);
    chk("oob_valid", 32'(EXT_readValid), 32'd1);
    chk("oob_x",     32'(EXT_pointX),    32'd0);
    chk("oob_err",   32'(o_status[2]),   32'd1);
    EXT_readReady = 0;
    @(negedge clk);

    // close frame
    EXT_doneProcessing = 1;
    @(negedge clk);
    EXT_doneProcessing = 0;
    chk("close_enable", 32'(EXT_enable),   32'd0);
    chk("close_done",   32'(o_frame_done), 32'd1);
    chk("close_state",  32'(o_status[1:0]), 32'd2);
    lbl_addr = 1;
    @(negedge clk);
    chk("after_done",   32'(o_frame_done),  32'd0);
    chk("write_count5", o_write_count,      32'd5);
    chk("no_restart",   32'(EXT_enable),    32'd0);
    chk("lbl_readout1", 32'(lbl_data),      32'h0055);
    $display("frame closed count=%0d lbl[1]=%h", o_write_count, lbl_data);

    do_start(0);
    chk("bad_start0_err",  32'(o_status[4]), 32'd1);
    chk("bad_start0_idle", 32'(load_ready),  32'd1);
    do_start(1025);
    chk("bad_start1025_st", 32'(o_status[1:0]), 32'd0);
    chk("bad_start1025_err", 32'(o_status[4]),  32'd1);

    // randomized frames, checked by the model each cycle
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 20; i++) begin
        load_valid = 1'($urandom_range(0, 1));
        load_id = ($urandom_range(0, 9) == 0) ? IDW'(1030) : IDW'($urandom_range(0, 70));
        load_x = 16'($urandom); load_y = 16'($urandom); load_z = 16'($urandom);
        lbl_addr = IDW'($urandom_range(0, 70));
        @(negedge clk);
      end
      load_valid = 0;
      if (f == 3) do_start(2000);
      sz = $urandom_range(1, 64);
      do_start(sz);
      $display("frame %0d size=%0d", f, sz);
      for (int c = 0; c < 200; c++) begin
        EXT_readReady = ($urandom_range(0, 2) != 0);
        EXT_readID = IDW'($urandom_range(0, sz + 5));
        EXT_writeValid = 1'($urandom_range(0, 1));
        EXT_writeID = IDW'($urandom_range(0, sz + 3));
        EXT_writeCustomField = 16'($urandom);
        lbl_addr = IDW'($urandom_range(0, 70));
        start = ($urandom_range(0, 30) == 0);
        start_pc_size = IDW'($urandom_range(0, 80));
        @(negedge clk);
      end
      start = 0;
      EXT_doneProcessing = 1; EXT_readReady = 1;
      @(negedge clk);
      EXT_doneProcessing = 0; EXT_writeValid = 0;
      for (int c = 0; c < 5; c++) begin
        EXT_readReady = 1'($urandom_range(0, 1));
        lbl_addr = IDW'($urandom_range(0, 70));
        @(negedge clk);
      end
      EXT_readReady = 0;
    end

    // reset in the middle of a frame
    do_start(8);
    EXT_readReady = 1; EXT_readID = 1;
    @(negedge clk);
    rst = 1; EXT_readReady = 0;
    @(negedge clk);
    chk("midrst_enable", 32'(EXT_enable),    32'd0);
    chk("midrst_idle",   32'(load_ready),    32'd1);
    chk("midrst_done",   32'(o_frame_done),  32'd0);
    chk("midrst_status", o_status,           32'd0);
    chk("midrst_rv",     32'(EXT_readValid), 32'd0);
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(o_frame_done), 32'd0);
    end
    $display("reset mid-frame done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
